// File: rtl/regfile_preload_pkg.sv
// rtl/regfile_preload_pkg.sv - shared sizes, FSM state encoding and helpers for the regfile preloader
package regfile_preload_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Saturating increment so a long session pins the count at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/regfile_preload_if.sv
// rtl/regfile_preload_if.sv - {reg, value} beat stream with valid/ready handshake
interface regfile_preload_if;
  import regfile_preload_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, in_addr, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_addr, in_data, in_last, output in_ready);

endinterface

// File: rtl/preload_verify.sv
// rtl/preload_verify.sv - readback compare of preload writes, built only with PRELOAD_VERIFY_EN
module preload_verify
  import regfile_preload_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mismatch
);

  logic [DATA_W-1:0] chk_data;

  // The write lands at the edge ending the rf_we cycle, so the following cycle reads it back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel   <= 1'b0;
      rd_addr  <= '0;
      chk_data <= '0;
      mismatch <= 1'b0;
    end else begin
      rd_sel   <= wr_valid;
      rd_addr  <= wr_valid ? wr_addr : '0;
      chk_data <= wr_data;
      if (clear) begin
        mismatch <= 1'b0;
      end else if (rd_sel && (rd_data != chk_data)) begin
        mismatch <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_preload.sv
// rtl/regfile_preload.sv - regfile write-port preloader; PRELOAD_VERIFY_EN adds readback compare
module regfile_preload
  import regfile_preload_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  regfile_preload_if.slave  beat,
  input  logic              cpu_rwe,
  input  logic [ADDR_W-1:0] cpu_rd,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wreg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  output logic              rf_rsel,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err_r0,
  output logic              mismatch
);

  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_PRE = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES);

  state_t            state;
  logic [CW-1:0]     drain_cnt;
  logic              in_ready_q;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              accept;
  logic              start_ok;

  assign beat.in_ready = in_ready_q;
  assign accept        = in_ready_q & beat.in_valid;
  assign start_ok      = start & (state == S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      drain_cnt  <= '0;
      in_ready_q <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_count   <= '0;
      err_r0     <= 1'b0;
      pend       <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      done <= 1'b0;
      pend <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            state      <= S_LOAD;
            in_ready_q <= 1'b1;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
            wr_count   <= '0;
            err_r0     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            pend      <= (beat.in_addr != '0);
            pend_addr <= beat.in_addr;
            pend_data <= beat.in_data;
            if (beat.in_addr == '0) begin
              err_r0 <= 1'b1;
            end else begin
              wr_count <= sat_inc(wr_count);
            end
            if (beat.in_last) begin
              state      <= S_DRAIN;
              in_ready_q <= 1'b0;
              drain_cnt  <= '0;
            end
          end
        end
        S_DRAIN: begin
          // drain_cnt==0 is the final write cycle; hold lasts HOLD_CYCLES beyond it.
          drain_cnt <= drain_cnt + CW'(1);
          if (drain_cnt == HOLD_PRE) begin
            done <= 1'b1;
          end
          if (drain_cnt == HOLD_END) begin
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wreg  = '0;
    rf_wdata = '0;
    if (pend) begin
      rf_we    = 1'b1;
      rf_wreg  = pend_addr;
      rf_wdata = pend_data;
    end else if (state == S_IDLE) begin
      rf_we    = cpu_rwe;
      rf_wreg  = cpu_rd;
      rf_wdata = cpu_wdata;
    end
  end

`ifdef PRELOAD_VERIFY_EN
  preload_verify u_verify (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (start_ok),
    .wr_valid (pend),
    .wr_addr  (pend_addr),
    .wr_data  (pend_data),
    .rd_data  (rf_rdata),
    .rd_sel   (rf_rsel),
    .rd_addr  (rf_raddr),
    .mismatch (mismatch)
  );
`else
  logic unused_rdata;
  assign unused_rdata = ^rf_rdata;
  assign rf_rsel      = 1'b0;
  assign rf_raddr     = '0;
  assign mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_preload.sv
// tb/tb_regfile_preload.sv - directed and random preload sessions against a behavioural regfile model
module tb_regfile_preload;
  import regfile_preload_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              cpu_rwe = 1'b0;
  logic [ADDR_W-1:0] cpu_rd = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wreg;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr;
  logic              rf_rsel;
  logic [DATA_W-1:0] rf_rdata;
  logic              cpu_hold, busy, done, err_r0, mismatch;
  logic [CNT_W-1:0]  wr_count;

  regfile_preload_if bi();

  regfile_preload dut (
    .clock(clock), .reset_n(reset_n), .start(start), .beat(bi),
    .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rsel(rf_rsel), .rf_rdata(rf_rdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .wr_count(wr_count),
    .err_r0(err_r0), .mismatch(mismatch)
  );

  always #5 clock = ~clock;

  // Regfile the DUT writes into, plus an optional single-bit corruption on readback.
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              fx_clear = 1'b1;
  logic              flip_en = 1'b0;
  logic [ADDR_W-1:0] flip_addr = '0;

  always @(posedge clock) begin
    if (fx_clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rf_we && rf_wreg != '0) begin
      regs[rf_wreg] <= rf_wdata;
    end
  end

  assign rf_rdata = rf_rsel ? (regs[rf_raddr] ^ ((flip_en && rf_raddr == flip_addr) ? 32'h1 : 32'h0)) : '0;

  logic [DATA_W-1:0] model [NUM_REGS];
  logic [ADDR_W-1:0] qa [$];
  logic [DATA_W-1:0] qd [$];
  int checks = 0;
  int errors = 0;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int r = 0; r < NUM_REGS; r++) chk($sformatf("reg%0d", r), regs[r], model[r]);
  endtask

  // gapmode: 0 none, 1 random idle cycles, 2 idle cycle before every beat after the first
  task automatic run_session(input int gapmode, input bit noise, input bit exp_mm);
    int n;
    int exp_cnt;
    bit exp_r0;
    int waitc;
    bit seen;
    n = qa.size();
    exp_cnt = 0;
    exp_r0 = 1'b0;
    start = 1'b1;
    bi.in_valid = 1'b1;
    bi.in_addr = qa[0];
    bi.in_data = qd[0];
    bi.in_last = (n == 1);
    chk("idle_in_ready", bi.in_ready, 0);
    step;
    start = 1'b0;
    chk("start_no_accept", rf_we, 0);
    chk("load_busy", busy, 1);
    chk("load_hold", cpu_hold, 1);
    chk("start_clr_mm", mismatch, 0);
    for (int i = 0; i < n; i++) begin
      if ((gapmode == 1 && $urandom_range(0, 2) == 0) || (gapmode == 2 && i > 0)) begin
        bi.in_valid = 1'b0;
        step;
        chk("gap_no_write", rf_we, 0);
        chk("gap_hold", cpu_hold, 1);
      end
      bi.in_valid = 1'b1;
      bi.in_addr = qa[i];
      bi.in_data = qd[i];
      bi.in_last = (i == n - 1);
      if (noise) begin
        start = ($urandom_range(0, 1) != 0);
        cpu_rwe = ($urandom_range(0, 1) != 0);
        cpu_rd = ADDR_W'($urandom);
        cpu_wdata = $urandom;
      end
      chk("load_in_ready", bi.in_ready, 1);
      step;
      start = 1'b0;
      cpu_rwe = 1'b0;
      bi.in_valid = 1'b0;
      bi.in_last = 1'b0;
      chk("beat_we", rf_we, qa[i] != 0);
      if (qa[i] != 0) begin
        chk("beat_wreg", rf_wreg, qa[i]);
        chk("beat_wdata", rf_wdata, qd[i]);
        model[qa[i]] = qd[i];
        exp_cnt++;
      end else begin
        exp_r0 = 1'b1;
      end
    end
    waitc = 0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step;
      waitc++;
      if (done) seen = 1'b1;
      else chk("drain_hold", cpu_hold, 1);
    end
    chk("done_seen", seen, 1);
    chk("done_latency", waitc, 2);
    chk("done_hold", cpu_hold, 1);
    step;
    chk("done_pulse", done, 0);
    chk("post_hold", cpu_hold, 0);
    chk("post_busy", busy, 0);
    chk("post_ready", bi.in_ready, 0);
    chk("wr_count", wr_count, (exp_cnt > 63) ? 63 : exp_cnt);
    chk("err_r0", err_r0, exp_r0);
    chk("mismatch", mismatch, exp_mm);
    check_regs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    bi.in_valid = 1'b0;
    bi.in_addr = '0;
    bi.in_data = '0;
    bi.in_last = 1'b0;
    step;
    step;
    chk("rst_in_ready", bi.in_ready, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_err_r0", err_r0, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_rsel", rf_rsel, 0);
    fx_clear = 1'b0;
    reset_n = 1'b1;
    step;

    // Basic load
    qa = '{5'd1, 5'd2, 5'd31};
    qd = '{32'd5, 32'hFFFF_FFF9, 32'h7FFF_FFFF};
    run_session(0, 1'b0, 1'b0);
    chk("basic_r1", regs[1], 32'd5);
    chk("basic_r2", regs[2], 32'hFFFF_FFF9);
    chk("basic_r31", regs[31], 32'h7FFF_FFFF);

    // Pass-through once idle
    cpu_rwe = 1'b1;
    cpu_rd = 5'd4;
    cpu_wdata = 32'd12;
    #1;
    chk("pass_we", rf_we, 1);
    chk("pass_wreg", rf_wreg, 4);
    chk("pass_wdata", rf_wdata, 12);
    step;
    model[4] = 32'd12;
    cpu_rwe = 1'b0;
    #1;
    chk("pass_we_off", rf_we, 0);
    chk("pass_r4", regs[4], 32'd12);

    // r0 beat
    qa = '{5'd0};
    qd = '{32'd99};
    run_session(0, 1'b0, 1'b0);

    // Duplicate address, later beat wins
    qa = '{5'd7, 5'd7};
    qd = '{32'd1, 32'd2};
    run_session(0, 1'b0, 1'b0);
    chk("dup_r7", regs[7], 32'd2);

    // Backpressure: valid toggles 1,0,1
    qa = '{5'd10, 5'd11, 5'd12, 5'd13};
    qd = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
    run_session(2, 1'b0, 1'b0);

    // Reset mid-session after two of four beats
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bi.in_valid = 1'b1;
      bi.in_addr = ADDR_W'(i + 1);
      bi.in_data = 32'h5500 + i;
      bi.in_last = 1'b0;
      step;
      chk("rst_sess_we", rf_we, 1);
      model[i + 1] = 32'h5500 + i;
    end
    bi.in_valid = 1'b0;
    step;
    bi.in_valid = 1'b1;
    bi.in_addr = 5'd3;
    bi.in_data = 32'h5502;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hold", cpu_hold, 0);
    chk("midrst_ready", bi.in_ready, 0);
    step;
    reset_n = 1'b1;
    step;
    bi.in_valid = 1'b0;
    step;
    chk("midrst_we", rf_we, 0);
    check_regs();

    // Count saturation
    qa.delete();
    qd.delete();
    for (int i = 0; i < 66; i++) begin
      qa.push_back(ADDR_W'($urandom_range(1, 31)));
      qd.push_back($urandom);
    end
    run_session(0, 1'b0, 1'b0);

    // Random sessions with gaps, stray start pulses and processor write noise
    for (int s = 0; s < 6; s++) begin
      int len;
      len = $urandom_range(1, 8);
      qa.delete();
      qd.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom_range(1, 31)));
        qd.push_back($urandom);
      end
      run_session(1, 1'b1, 1'b0);
    end

`ifdef PRELOAD_VERIFY_EN
    qa = '{5'd3, 5'd5, 5'd6};
    qd = '{32'h33, 32'h55, 32'h66};
    flip_addr = 5'd5;
    flip_en = 1'b1;
    run_session(0, 1'b0, 1'b1);
    flip_en = 1'b0;
    step;
    step;
    chk("mm_sticky", mismatch, 1);
    qa = '{5'd8};
    qd = '{32'h88};
    run_session(0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
